// File: rtl/led_pattern_gen_if.sv
// Pin-level bundle for led_pattern_gen: switch input plus LED and step-tick outputs.
// The master side drives the mode switches; the slave side is the generator.
interface led_pattern_gen_if #(
    parameter int NUM_LEDS = 8
);
    logic [1:0]          MODE_IN;
    logic [NUM_LEDS-1:0] LED_OUT;
    logic                TICK_OUT;

    modport master (
        output MODE_IN,
        input  LED_OUT,
        input  TICK_OUT
    );

    modport slave (
        input  MODE_IN,
        output LED_OUT,
        output TICK_OUT
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step tick driving count / scan / breathe / lamp-test patterns.
// Define LED_PATTERN_BREATHE_EN to build the PWM breathing pattern; otherwise mode 2 behaves as count.
module led_pattern_gen #(
    parameter int NUM_LEDS       = 8,
    parameter int PRESCALE_WIDTH = 20,
    parameter int PWM_WIDTH      = 8
) (
    input  logic              CLK_IN,
    input  logic              RST_N_IN,
    led_pattern_gen_if.slave  bus
);
    localparam int POS_W = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0] POS_BEFORE = POS_W'(NUM_LEDS - 2);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_LAMP    = 2'd3
    } mode_e;

    logic [1:0]                sync1_q, sync1_d;
    logic [1:0]                sync2_q, sync2_d;
    mode_e                     mode_q, mode_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      tick_q, tick_d;
    logic [NUM_LEDS-1:0]       cnt_q, cnt_d;
    logic [POS_W-1:0]          pos_q, pos_d;
    logic                      scan_down_q, scan_down_d;
    logic [NUM_LEDS-1:0]       led_q, led_d;
`ifdef LED_PATTERN_BREATHE_EN
    logic [PWM_WIDTH-1:0]      duty_q, duty_d;
    logic                      duty_down_q, duty_down_d;
    logic [PWM_WIDTH-1:0]      pwm_cnt_q, pwm_cnt_d;
`endif

    logic                      mode_change;
    logic                      tick;
    logic [NUM_LEDS-1:0]       scan_leds;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_scan_decode
            assign scan_leds[gi] = (pos_q == POS_W'(gi));
        end
    endgenerate

    always_comb begin
        sync1_d     = bus.MODE_IN;
        sync2_d     = sync1_q;
        mode_change = (mode_e'(sync2_q) != mode_q);
        tick        = &presc_q;

        mode_d      = mode_q;
        presc_d     = presc_q + PRESCALE_WIDTH'(1);
        tick_d      = tick;
        cnt_d       = cnt_q;
        pos_d       = pos_q;
        scan_down_d = scan_down_q;
`ifdef LED_PATTERN_BREATHE_EN
        duty_d      = duty_q;
        duty_down_d = duty_down_q;
        pwm_cnt_d   = pwm_cnt_q + PWM_WIDTH'(1);
`endif

        // A mode change restarts everything and swallows a coincident tick.
        if (mode_change) begin
            mode_d      = mode_e'(sync2_q);
            presc_d     = '0;
            cnt_d       = '0;
            pos_d       = '0;
            scan_down_d = 1'b0;
`ifdef LED_PATTERN_BREATHE_EN
            duty_d      = '0;
            duty_down_d = 1'b0;
            pwm_cnt_d   = '0;
`endif
        end else if (tick) begin
            cnt_d = cnt_q + NUM_LEDS'(1);

            if (!scan_down_q) begin
                if (pos_q == POS_LAST) begin
                    scan_down_d = 1'b1;
                    pos_d       = POS_BEFORE;
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    scan_down_d = 1'b0;
                    pos_d       = POS_W'(1);
                end else begin
                    pos_d = pos_q - POS_W'(1);
                end
            end

`ifdef LED_PATTERN_BREATHE_EN
            if (!duty_down_q) begin
                if (duty_q == '1) begin
                    duty_down_d = 1'b1;
                    duty_d      = duty_q - PWM_WIDTH'(1);
                end else begin
                    duty_d = duty_q + PWM_WIDTH'(1);
                end
            end else begin
                if (duty_q == '0) begin
                    duty_down_d = 1'b0;
                    duty_d      = duty_q + PWM_WIDTH'(1);
                end else begin
                    duty_d = duty_q - PWM_WIDTH'(1);
                end
            end
`endif
        end

        case (mode_q)
            MODE_COUNT:   led_d = cnt_q;
            MODE_SCAN:    led_d = scan_leds;
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: led_d = {NUM_LEDS{pwm_cnt_q < duty_q}};
`else
            MODE_BREATHE: led_d = cnt_q;
`endif
            MODE_LAMP:    led_d = '1;
            default:      led_d = '0;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            mode_q      <= MODE_COUNT;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            cnt_q       <= '0;
            pos_q       <= '0;
            scan_down_q <= 1'b0;
            led_q       <= '0;
`ifdef LED_PATTERN_BREATHE_EN
            duty_q      <= '0;
            duty_down_q <= 1'b0;
            pwm_cnt_q   <= '0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            scan_down_q <= scan_down_d;
            led_q       <= led_d;
`ifdef LED_PATTERN_BREATHE_EN
            duty_q      <= duty_d;
            duty_down_q <= duty_down_d;
            pwm_cnt_q   <= pwm_cnt_d;
`endif
        end
    end

    assign bus.LED_OUT  = led_q;
    assign bus.TICK_OUT = tick_q;
endmodule
